// File: rtl/cordic_rot_arbiter.sv
// cordic_rot_arbiter: round-robin sharing of one pipelined CORDIC rotation engine with in-order result routing
module cordic_rot_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int ANGLE_WIDTH  = 16,
  parameter int N_REQ        = 2,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [DATA_WIDTH*N_REQ-1:0]   req_xin_flat,
  input  logic [DATA_WIDTH*N_REQ-1:0]   req_yin_flat,
  input  logic [ANGLE_WIDTH*N_REQ-1:0]  req_angle_flat,
  input  logic [2*N_REQ-1:0]            req_quad_flat,
  input  logic [N_REQ-1:0]              req_microRot_n,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_xout,
  output logic [DATA_WIDTH-1:0]         rsp_yout,
  output logic                          cordic_rot_en,
  output logic [DATA_WIDTH-1:0]         cordic_rot_xin_reg,
  output logic [DATA_WIDTH-1:0]         cordic_rot_yin_reg,
  output logic [ANGLE_WIDTH-1:0]        cordic_rot_angle_in_reg,
  output logic [1:0]                    cordic_rot_quad_in,
  output logic                          cordic_rot_angle_microRot_n,
  output logic                          cordic_rot_microRot_ext_vld,
  input  logic                          cordic_rot_opvld,
  input  logic [DATA_WIDTH-1:0]         cordic_rot_xout,
  input  logic [DATA_WIDTH-1:0]         cordic_rot_yout,
  input  logic                          drain_req,
  output logic                          drained,
  output logic                          err_unexpected_vld
);
  localparam int TW = $clog2(N_REQ);
  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {ACTIVE, DRAIN, IDLE_DRAINED} state_t;
  state_t state, state_nxt;
  logic [TW-1:0] ptr, gidx;
  logic [N_REQ-1:0] gnt;
  logic [CW-1:0] inflight_cnt;
  logic [TW-1:0] tag_mem [MAX_INFLIGHT];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic can_issue, grant, pop;
  assign can_issue = (inflight_cnt < CW'(MAX_INFLIGHT)) && !drain_req;
  assign req_ready = can_issue ? gnt : '0;
  assign grant = can_issue && |gnt;
  assign pop = cordic_rot_opvld && inflight_cnt != '0;
  assign cordic_rot_microRot_ext_vld = 1'b0;
  // round-robin search starting just above the last granted requester
  always_comb begin
    gnt = '0;
    gidx = ptr;
    for (int k = 1; k <= N_REQ; k++)
      if (gnt == '0 && req_valid[(int'(ptr) + k) % N_REQ]) begin
        gnt[(int'(ptr) + k) % N_REQ] = 1'b1;
        gidx = TW'((int'(ptr) + k) % N_REQ);
      end
  end
  // register the granted operands and strobe the engine the following cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cordic_rot_en <= 1'b0;
      cordic_rot_xin_reg <= '0;
      cordic_rot_yin_reg <= '0;
      cordic_rot_angle_in_reg <= '0;
      cordic_rot_quad_in <= '0;
      cordic_rot_angle_microRot_n <= 1'b0;
    end else begin
      cordic_rot_en <= grant;
      if (grant) begin
        cordic_rot_xin_reg <= req_xin_flat[gidx*DATA_WIDTH +: DATA_WIDTH];
        cordic_rot_yin_reg <= req_yin_flat[gidx*DATA_WIDTH +: DATA_WIDTH];
        cordic_rot_angle_in_reg <= req_angle_flat[gidx*ANGLE_WIDTH +: ANGLE_WIDTH];
        cordic_rot_quad_in <= req_quad_flat[gidx*2 +: 2];
        cordic_rot_angle_microRot_n <= req_microRot_n[gidx];
      end
    end
  end
  // owner tags of in-flight ops; storage needs no reset since pointers/count guard it
  always_ff @(posedge clk) begin
    if (grant) tag_mem[wr_ptr] <= gidx;
  end
  // rr pointer, fifo pointers, in-flight count and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= TW'(N_REQ - 1);
      wr_ptr <= '0;
      rd_ptr <= '0;
      inflight_cnt <= '0;
      err_unexpected_vld <= 1'b0;
    end else begin
      if (grant) ptr <= gidx;
      if (grant) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      inflight_cnt <= inflight_cnt + CW'(grant) - CW'(pop);
      if (cordic_rot_opvld && inflight_cnt == '0) err_unexpected_vld <= 1'b1;
    end
  end
  // route each returning result to the owner at the head of the tag fifo
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_xout <= '0;
      rsp_yout <= '0;
    end else begin
      rsp_valid <= pop ? N_REQ'(1) << tag_mem[rd_ptr] : '0;
      if (pop) begin
        rsp_xout <= cordic_rot_xout;
        rsp_yout <= cordic_rot_yout;
      end
    end
  end
  // drain fsm state register
  always_ff @(posedge clk) begin
    if (rst) state <= ACTIVE;
    else state <= state_nxt;
  end
  // drain fsm next state
  always_comb begin
    state_nxt = state;
    case (state)
      ACTIVE:       state_nxt = drain_req ? DRAIN : ACTIVE;
      DRAIN:        state_nxt = inflight_cnt == '0 ? IDLE_DRAINED : DRAIN;
      IDLE_DRAINED: state_nxt = drain_req ? IDLE_DRAINED : ACTIVE;
      default:      state_nxt = ACTIVE;
    endcase
  end
  // drain fsm output
  always_comb drained = state == IDLE_DRAINED;
endmodule

// File: tb/tb_cordic_rot_arbiter.sv
// tb_cordic_rot_arbiter: scoreboard bench with a behavioural CORDIC stand-in and a cycle model of the arbiter
module tb_cordic_rot_arbiter;
  localparam int N = 2;
  localparam int MAXI = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] vld = '0;
  logic [15:0] xs [2];
  logic [15:0] ys [2];
  logic [15:0] as [2];
  logic [1:0] qs [2];
  logic ms [2];
  logic drain_req = 1'b0;
  logic force_vld = 1'b0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [15:0] rsp_xout, rsp_yout, cordic_rot_xin_reg, cordic_rot_yin_reg, cordic_rot_angle_in_reg;
  logic [15:0] cordic_rot_xout, cordic_rot_yout;
  logic [1:0] cordic_rot_quad_in;
  logic cordic_rot_en, cordic_rot_angle_microRot_n, cordic_rot_microRot_ext_vld;
  logic cordic_rot_opvld, drained, err;
  cordic_rot_arbiter #(.DATA_WIDTH(16), .ANGLE_WIDTH(16), .N_REQ(N), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst),
    .req_valid(vld), .req_ready(req_ready),
    .req_xin_flat({xs[1], xs[0]}), .req_yin_flat({ys[1], ys[0]}),
    .req_angle_flat({as[1], as[0]}), .req_quad_flat({qs[1], qs[0]}),
    .req_microRot_n({ms[1], ms[0]}),
    .rsp_valid(rsp_valid), .rsp_xout(rsp_xout), .rsp_yout(rsp_yout),
    .cordic_rot_en(cordic_rot_en),
    .cordic_rot_xin_reg(cordic_rot_xin_reg), .cordic_rot_yin_reg(cordic_rot_yin_reg),
    .cordic_rot_angle_in_reg(cordic_rot_angle_in_reg), .cordic_rot_quad_in(cordic_rot_quad_in),
    .cordic_rot_angle_microRot_n(cordic_rot_angle_microRot_n),
    .cordic_rot_microRot_ext_vld(cordic_rot_microRot_ext_vld),
    .cordic_rot_opvld(cordic_rot_opvld), .cordic_rot_xout(cordic_rot_xout), .cordic_rot_yout(cordic_rot_yout),
    .drain_req(drain_req), .drained(drained), .err_unexpected_vld(err)
  );
  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [31:0] cm(logic [15:0] x, logic [15:0] y, logic [15:0] a, logic [1:0] q, logic m);
    return {x + a, y - a + {13'b0, q, m}};
  endfunction
  // stand-in for the pipelined rotation engine with a run-time selectable latency
  int lat = 4;
  logic sr_v [16];
  logic [15:0] sr_x [16];
  logic [15:0] sr_y [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) sr_v[i] <= 1'b0;
    end else begin
      sr_v[0] <= cordic_rot_en;
      {sr_x[0], sr_y[0]} <= cm(cordic_rot_xin_reg, cordic_rot_yin_reg, cordic_rot_angle_in_reg,
                               cordic_rot_quad_in, cordic_rot_angle_microRot_n);
      for (int i = 1; i < 16; i++) begin
        sr_v[i] <= sr_v[i-1];
        sr_x[i] <= sr_x[i-1];
        sr_y[i] <= sr_y[i-1];
      end
    end
  end
  assign cordic_rot_opvld = sr_v[lat-1] | force_vld;
  assign cordic_rot_xout = sr_x[lat-1];
  assign cordic_rot_yout = sr_y[lat-1];
  // cycle model of the arbiter and the response scoreboard
  typedef struct {int own; logic [15:0] x; logic [15:0] y; int gc;} exp_t;
  exp_t sb [$];
  exp_t e;
  int m_ptr, m_cnt, m_st, cyc, nrsp, run, max_run, j;
  logic m_en, m_err, m_pend, p;
  logic [1:0] eg;
  logic [15:0] ex, ey;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_ptr = N - 1; m_cnt = 0; m_st = 0; m_en = 0; m_err = 0; m_pend = 0; run = 0;
      sb.delete();
    end else begin
      eg = '0;
      if (m_cnt < MAXI && !drain_req)
        for (int k = 1; k <= N; k++) begin
          j = (m_ptr + k) % N;
          if (eg == '0 && vld[j]) eg[j] = 1'b1;
        end
      chk("ready", 32'(req_ready), 32'(eg));
      chk("rot_en", 32'(cordic_rot_en), 32'(m_en));
      chk("inflight", 32'(dut.inflight_cnt), m_cnt);
      chk("err", 32'(err), 32'(m_err));
      chk("drained", 32'(drained), 32'(m_st == 2));
      if (m_pend && sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 1 << e.own);
        chk("rsp_x", 32'(rsp_xout), 32'(e.x));
        chk("rsp_y", 32'(rsp_yout), 32'(e.y));
        chk("latency", cyc - e.gc, lat + 2);
        nrsp++;
      end else chk("rsp_idle", 32'(rsp_valid), 0);
      run = cordic_rot_en ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (eg != '0) begin
        j = eg[1] ? 1 : 0;
        {ex, ey} = cm(xs[j], ys[j], as[j], qs[j], ms[j]);
        sb.push_back('{j, ex, ey, cyc});
        m_ptr = j;
      end
      p = cordic_rot_opvld && m_cnt > 0;
      if (cordic_rot_opvld && m_cnt == 0) m_err = 1'b1;
      m_pend = p;
      m_st = m_st == 0 ? (drain_req ? 1 : 0) : m_st == 1 ? (m_cnt == 0 ? 2 : 1) : (drain_req ? 2 : 0);
      m_cnt = m_cnt + int'(eg != '0) - int'(p);
      m_en = eg != '0;
    end
  end
  int ntk = 0;
  logic [1:0] tk;
  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      tk = vld & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (tk[i]) begin
          xs[i] = 16'($urandom); ys[i] = 16'($urandom); as[i] = 16'($urandom);
          qs[i] = 2'($urandom); ms[i] = 1'($urandom);
          ntk++;
        end
    end
  endtask
  task automatic wait_xfers(int n0, int want);
    for (int i = 0; i < 40 && ntk - n0 < want; i++) step(1);
  endtask
  task automatic chk_reset_outs();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_en", 32'(cordic_rot_en), 0);
    chk("rst_ops", {cordic_rot_xin_reg, cordic_rot_yin_reg}, 0);
    chk("rst_ang", {cordic_rot_angle_in_reg, 13'b0, cordic_rot_quad_in, cordic_rot_angle_microRot_n}, 0);
    chk("rst_ext", 32'(cordic_rot_microRot_ext_vld), 0);
    chk("rst_rsp", {rsp_xout, rsp_yout}, 0);
    chk("rst_rspv", 32'(rsp_valid), 0);
    chk("rst_flags", {drained, err}, 0);
  endtask
  int n0, r0;
  initial begin
    for (int i = 0; i < N; i++) begin
      xs[i] = 16'($urandom); ys[i] = 16'($urandom); as[i] = 16'($urandom); qs[i] = '0; ms[i] = 1'b0;
    end
    step(3);
    rst = 1'b0;
    step(1);
    chk_reset_outs();
    lat = 4;
    xs[0] = 16'd100; ys[0] = '0; as[0] = '0; qs[0] = '0; ms[0] = 1'b0;
    n0 = ntk; r0 = nrsp;
    vld = 2'b01;
    wait_xfers(n0, 1);
    vld = '0;
    step(20);
    chk("t1_grants", ntk - n0, 1);
    chk("t1_rsps", nrsp - r0, 1);
    lat = 2;
    max_run = 0; n0 = ntk; r0 = nrsp;
    vld = 2'b11;
    step(8);
    vld = '0;
    step(20);
    chk("t2_en_run", max_run, 8);
    chk("t2_rsps", nrsp - r0, 8);
    lat = 10;
    vld = 2'b01;
    step(40);
    vld = '0;
    step(25);
    lat = 1;
    vld = 2'b01;
    step(10);
    vld = '0;
    step(20);
    lat = 6;
    n0 = ntk;
    vld = 2'b01;
    wait_xfers(n0, 3);
    drain_req = 1'b1;
    step(20);
    chk("t5_drained", 32'(drained), 1);
    chk("t5_held", ntk - n0, 3);
    drain_req = 1'b0;
    step(3);
    chk("t5_resume", 32'(ntk - n0 > 3), 1);
    vld = '0;
    step(20);
    lat = 10;
    n0 = ntk;
    vld = 2'b11;
    wait_xfers(n0, 3);
    vld = '0;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    chk_reset_outs();
    r0 = nrsp;
    force_vld = 1'b1;
    step(1);
    force_vld = 1'b0;
    step(15);
    chk("t6_err", 32'(err), 1);
    chk("t6_no_rsp", nrsp - r0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
